fmc_adc_trig_arbiter: RTL and testbench

Trigger arbiter and shot scheduler sitting between the trigger sources and the acquisition FSM of fmc_adc_100Ms_core. It masks the eight trigger request lines with the TRIG_EN register, delays the external trigger by EXT_TRIG_DLY cycles, and issues one trigger pulse per shot while armed. It also latches the source vector and timetag for each shot, enforces a hold-off between shots, and reports end of the multi-shot sequence.

---
 rtl/fmc_adc_trig_pkg.sv | 28 ++
 rtl/fmc_adc_ext_trig_delay.sv | 47 ++++
 rtl/fmc_adc_trig_arbiter.sv | 176 +++++++++++++++++
 tb/tb_fmc_adc_trig_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fmc_adc_trig_pkg.sv
// Shared definitions for the FMC ADC trigger arbiter: trigger source indices,
// arbiter state encoding and the trigger source vector type.
package fmc_adc_trig_pkg;

    localparam int C_TRIG_EXT      = 0;
    localparam int C_TRIG_SW       = 1;
    localparam int C_TRIG_TIME     = 2;
    localparam int C_TRIG_ALT_TIME = 3;
    localparam int C_TRIG_CH1      = 4;
    localparam int C_TRIG_CH2      = 5;
    localparam int C_TRIG_CH3      = 6;
    localparam int C_TRIG_CH4      = 7;
    localparam int C_NUM_TRIG_SRC  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } t_trig_arb_state;

    typedef logic [C_NUM_TRIG_SRC-1:0] t_trig_src;

    // True when at least one source in the vector is requesting.
    function automatic logic trig_any(input t_trig_src src);
        return |src;
    endfunction

endpackage

// File: rtl/fmc_adc_ext_trig_delay.sv
// External trigger delay line: a masked ext pulse loads a down-counter and a
// single pulse is emitted dly cycles later; dly = 0 is a straight pass-through.
module fmc_adc_ext_trig_delay #(
    parameter int g_DLY_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   ext_pulse,
    input  logic [g_DLY_WIDTH-1:0] dly,
    output logic                   pulse_out
);

    localparam logic [g_DLY_WIDTH-1:0] C_CNT_ONE = g_DLY_WIDTH'(1);

    logic [g_DLY_WIDTH-1:0] cnt_reg;
    logic [g_DLY_WIDTH-1:0] cnt_next;
    logic                   dly_zero;
    logic                   running;

    assign dly_zero = (dly == '0);
    assign running  = (cnt_reg != '0);

    // Pulses arriving while a delay is already in flight are dropped.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (running) begin
            cnt_next = cnt_reg - C_CNT_ONE;
        end else if (ext_pulse && !dly_zero) begin
            cnt_next = dly;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // The last count of a loaded delay is the cycle the delayed pulse appears.
    assign pulse_out = (cnt_reg == C_CNT_ONE) || (dly_zero && ext_pulse);

endmodule

// File: rtl/fmc_adc_trig_arbiter.sv
// Trigger arbiter / shot scheduler between trigger sources and the acquisition
// FSM. Build option FMC_ADC_TRIG_MISSED_CNT_EN enables the missed-request counter.
module fmc_adc_trig_arbiter
    import fmc_adc_trig_pkg::*;
#(
    parameter int g_DLY_WIDTH     = 32,
    parameter int g_HOLDOFF_WIDTH = 16,
    parameter int g_SHOTS_WIDTH   = 16,
    parameter int g_TAG_WIDTH     = 64
) (
    input  logic                       sys_clk_i,
    input  logic                       sys_rst_i,
    input  logic [7:0]                 trig_req_i,
    input  logic [7:0]                 trig_en_i,
    input  logic [g_DLY_WIDTH-1:0]     ext_dly_i,
    input  logic [g_HOLDOFF_WIDTH-1:0] holdoff_i,
    input  logic [g_SHOTS_WIDTH-1:0]   shots_i,
    input  logic                       arm_i,
    input  logic                       disarm_i,
    input  logic [g_TAG_WIDTH-1:0]     tag_i,
    output logic                       trig_o,
    output logic [7:0]                 trig_src_o,
    output logic [g_TAG_WIDTH-1:0]     trig_tag_o,
    output logic                       armed_o,
    output logic                       busy_o,
    output logic [g_SHOTS_WIDTH-1:0]   shots_left_o,
    output logic                       done_o,
    output logic [15:0]                missed_cnt_o
);

    localparam logic [g_SHOTS_WIDTH-1:0]   C_SHOT_ONE = g_SHOTS_WIDTH'(1);
    localparam logic [g_HOLDOFF_WIDTH-1:0] C_HOLD_ONE = g_HOLDOFF_WIDTH'(1);

    t_trig_arb_state              state_reg;
    t_trig_src                    req_m;
    t_trig_src                    eff;
    t_trig_src                    trig_src_reg;
    logic [g_TAG_WIDTH-1:0]       trig_tag_reg;
    logic [g_SHOTS_WIDTH-1:0]     shots_left_reg;
    logic [g_HOLDOFF_WIDTH-1:0]   holdoff_cnt_reg;
    logic                         trig_reg;
    logic                         done_reg;
    logic                         armed_reg;
    logic                         busy_reg;
    logic                         ext_dly_pulse;
    logic                         eff_any;
    logic                         last_shot;
    logic                         dly_clr;
    logic                         arm_accept;

    assign req_m = t_trig_src'(trig_req_i & trig_en_i);

    // Effective request vector: ext source comes from the delay line.
    generate
        for (genvar gi = 0; gi < C_NUM_TRIG_SRC; gi++) begin : g_eff
            if (gi == C_TRIG_EXT) begin : g_ext
                assign eff[gi] = ext_dly_pulse;
            end else begin : g_direct
                assign eff[gi] = req_m[gi];
            end
        end
    endgenerate

    assign eff_any    = trig_any(eff);
    assign last_shot  = (state_reg == ARMED) && eff_any && (shots_left_reg == C_SHOT_ONE);
    assign arm_accept = (state_reg == IDLE) && arm_i && !disarm_i;
    assign dly_clr    = disarm_i || last_shot;

    fmc_adc_ext_trig_delay #(
        .g_DLY_WIDTH (g_DLY_WIDTH)
    ) u_ext_dly (
        .clk       (sys_clk_i),
        .rst       (sys_rst_i),
        .clr       (dly_clr),
        .ext_pulse (req_m[C_TRIG_EXT]),
        .dly       (ext_dly_i),
        .pulse_out (ext_dly_pulse)
    );

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_reg       <= IDLE;
            trig_reg        <= 1'b0;
            done_reg        <= 1'b0;
            armed_reg       <= 1'b0;
            busy_reg        <= 1'b0;
            trig_src_reg    <= '0;
            trig_tag_reg    <= '0;
            shots_left_reg  <= '0;
            holdoff_cnt_reg <= '0;
        end else begin
            trig_reg <= 1'b0;
            done_reg <= 1'b0;
            if (disarm_i) begin
                // Abort overrides any request or arm seen in the same cycle.
                state_reg       <= IDLE;
                armed_reg       <= 1'b0;
                busy_reg        <= 1'b0;
                holdoff_cnt_reg <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (arm_i) begin
                            state_reg      <= ARMED;
                            armed_reg      <= 1'b1;
                            busy_reg       <= 1'b1;
                            shots_left_reg <= (shots_i == '0) ? C_SHOT_ONE : shots_i;
                        end
                    end
                    ARMED: begin
                        if (eff_any) begin
                            trig_reg       <= 1'b1;
                            trig_src_reg   <= eff;
                            trig_tag_reg   <= tag_i;
                            shots_left_reg <= shots_left_reg - C_SHOT_ONE;
                            if (last_shot) begin
                                done_reg  <= 1'b1;
                                state_reg <= IDLE;
                                armed_reg <= 1'b0;
                                busy_reg  <= 1'b0;
                            end else if (holdoff_i != '0) begin
                                state_reg       <= HOLDOFF;
                                armed_reg       <= 1'b0;
                                holdoff_cnt_reg <= holdoff_i;
                            end
                        end
                    end
                    HOLDOFF: begin
                        // Re-arm on the cycle the count reaches zero.
                        if (holdoff_cnt_reg <= C_HOLD_ONE) begin
                            state_reg       <= ARMED;
                            armed_reg       <= 1'b1;
                            holdoff_cnt_reg <= '0;
                        end else begin
                            holdoff_cnt_reg <= holdoff_cnt_reg - C_HOLD_ONE;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        armed_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef FMC_ADC_TRIG_MISSED_CNT_EN
    logic [15:0] missed_cnt_reg;

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            missed_cnt_reg <= '0;
        end else if (arm_accept) begin
            missed_cnt_reg <= '0;
        end else if ((state_reg == HOLDOFF) && eff_any && (missed_cnt_reg != 16'hFFFF)) begin
            missed_cnt_reg <= missed_cnt_reg + 16'd1;
        end
    end

    assign missed_cnt_o = missed_cnt_reg;
`else
    logic unused_arm_accept;
    assign unused_arm_accept = arm_accept;
    assign missed_cnt_o      = 16'h0000;
`endif

    assign trig_o       = trig_reg;
    assign done_o       = done_reg;
    assign armed_o      = armed_reg;
    assign busy_o       = busy_reg;
    assign trig_src_o   = trig_src_reg;
    assign trig_tag_o   = trig_tag_reg;
    assign shots_left_o = shots_left_reg;

endmodule

// File: tb/tb_fmc_adc_trig_arbiter.sv
// Directed testbench for fmc_adc_trig_arbiter with hand-computed expectations.
module tb_fmc_adc_trig_arbiter;

    localparam int DW = 32;
    localparam int HW = 16;
    localparam int SW = 16;
    localparam int TW = 64;

`ifdef FMC_ADC_TRIG_MISSED_CNT_EN
    localparam logic [63:0] EXP_MISSED = 64'd1;
`else
    localparam logic [63:0] EXP_MISSED = 64'd0;
`endif

    logic          sys_clk_i = 1'b0;
    logic          sys_rst_i = 1'b1;
    logic [7:0]    trig_req_i = '0;
    logic [7:0]    trig_en_i = '0;
    logic [DW-1:0] ext_dly_i = '0;
    logic [HW-1:0] holdoff_i = '0;
    logic [SW-1:0] shots_i = '0;
    logic          arm_i = 1'b0;
    logic          disarm_i = 1'b0;
    logic [TW-1:0] tag_i = '0;
    logic          trig_o;
    logic [7:0]    trig_src_o;
    logic [TW-1:0] trig_tag_o;
    logic          armed_o;
    logic          busy_o;
    logic [SW-1:0] shots_left_o;
    logic          done_o;
    logic [15:0]   missed_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    fmc_adc_trig_arbiter dut (
        .sys_clk_i    (sys_clk_i),
        .sys_rst_i    (sys_rst_i),
        .trig_req_i   (trig_req_i),
        .trig_en_i    (trig_en_i),
        .ext_dly_i    (ext_dly_i),
        .holdoff_i    (holdoff_i),
        .shots_i      (shots_i),
        .arm_i        (arm_i),
        .disarm_i     (disarm_i),
        .tag_i        (tag_i),
        .trig_o       (trig_o),
        .trig_src_o   (trig_src_o),
        .trig_tag_o   (trig_tag_o),
        .armed_o      (armed_o),
        .busy_o       (busy_o),
        .shots_left_o (shots_left_o),
        .done_o       (done_o),
        .missed_cnt_o (missed_cnt_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    always @(negedge sys_clk_i) begin
        if (trig_o)
            $display("trig src=0x%02h tag=0x%016h shots_left=%0d done=%0b",
                     trig_src_o, trig_tag_o, shots_left_o, done_o);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge sys_clk_i);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_arm(input logic [SW-1:0] shots);
        shots_i = shots;
        arm_i   = 1'b1;
        step();
        arm_i   = 1'b0;
    endtask

    task automatic do_disarm();
        disarm_i = 1'b1;
        step();
        disarm_i = 1'b0;
    endtask

    initial begin
        int trig_cnt;
        logic exp_bit;

        // Reset state
        #12;
        check("rst_trig",   64'(trig_o), 64'd0);
        check("rst_armed",  64'(armed_o), 64'd0);
        check("rst_busy",   64'(busy_o), 64'd0);
        check("rst_shots",  64'(shots_left_o), 64'd0);
        check("rst_src",    64'(trig_src_o), 64'd0);
        sys_rst_i = 1'b0;
        step();

        // Single shot, software trigger
        trig_en_i = 8'h02;
        do_arm(16'd1);
        check("s1_armed", 64'(armed_o), 64'd1);
        check("s1_busy",  64'(busy_o), 64'd1);
        check("s1_shots", 64'(shots_left_o), 64'd1);
        step_n(3);
        tag_i = 64'hDEAD_BEEF_0000_0010;
        trig_req_i = 8'h02;
        step();
        trig_req_i = 8'h00;
        tag_i = 64'h0;
        check("s1_trig",  64'(trig_o), 64'd1);
        check("s1_src",   64'(trig_src_o), 64'h02);
        check("s1_tag",   trig_tag_o, 64'hDEAD_BEEF_0000_0010);
        check("s1_done",  64'(done_o), 64'd1);
        check("s1_left",  64'(shots_left_o), 64'd0);
        step();
        check("s1_armed_after", 64'(armed_o), 64'd0);
        check("s1_trig_after",  64'(trig_o), 64'd0);
        check("s1_done_after",  64'(done_o), 64'd0);

        // Ext delay of 3 with a second ext pulse while the delay runs
        trig_en_i = 8'h01;
        ext_dly_i = 32'd3;
        do_arm(16'd2);
        trig_req_i = 8'h01;
        step();
        check("s2_c21", 64'(trig_o), 64'd0);
        step();
        trig_req_i = 8'h00;
        check("s2_c22", 64'(trig_o), 64'd0);
        step();
        check("s2_c23", 64'(trig_o), 64'd0);
        step();
        check("s2_c24", 64'(trig_o), 64'd1);
        check("s2_src", 64'(trig_src_o), 64'h01);
        check("s2_left", 64'(shots_left_o), 64'd1);
        trig_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (trig_o) trig_cnt++;
        end
        check("s2_extra_trigs", 64'(trig_cnt), 64'd0);
        do_disarm();
        check("s2_disarmed", 64'(armed_o), 64'd0);
        ext_dly_i = 32'd0;

        // Three shots with hold-off 5; sw pulses at cycles 0, 3, 7, 20
        trig_en_i = 8'h02;
        holdoff_i = 16'd5;
        do_arm(16'd3);
        for (int c = 0; c < 25; c++) begin
            trig_req_i = (c == 0 || c == 3 || c == 7 || c == 20) ? 8'h02 : 8'h00;
            step();
            trig_req_i = 8'h00;
            exp_bit = (c + 1 == 1) || (c + 1 == 8) || (c + 1 == 21);
            check($sformatf("s3_trig_c%0d", c + 1), 64'(trig_o), 64'(exp_bit));
            check($sformatf("s3_done_c%0d", c + 1), 64'(done_o), 64'(c + 1 == 21));
        end
        check("s3_missed", 64'(missed_cnt_o), EXP_MISSED);
        check("s3_left",   64'(shots_left_o), 64'd0);
        check("s3_armed",  64'(armed_o), 64'd0);

        // Simultaneous sources and a disabled source
        trig_en_i = 8'hF2;
        holdoff_i = 16'd0;
        do_arm(16'd2);
        check("s4_missed_clr", 64'(missed_cnt_o), 64'd0);
        trig_req_i = 8'h12;
        step();
        trig_req_i = 8'h00;
        check("s4_trig", 64'(trig_o), 64'd1);
        check("s4_src",  64'(trig_src_o), 64'h12);
        trig_en_i  = 8'hD2;
        trig_req_i = 8'h20;
        step();
        trig_req_i = 8'h00;
        check("s4_masked_trig", 64'(trig_o), 64'd0);
        check("s4_src_hold",    64'(trig_src_o), 64'h12);
        check("s4_left",        64'(shots_left_o), 64'd1);
        do_disarm();

        // Disarm coinciding with a request, and with arm
        trig_en_i = 8'h02;
        do_arm(16'd2);
        check("s5_left_armed", 64'(shots_left_o), 64'd2);
        disarm_i   = 1'b1;
        trig_req_i = 8'h02;
        step();
        disarm_i   = 1'b0;
        trig_req_i = 8'h00;
        check("s5_trig",  64'(trig_o), 64'd0);
        check("s5_done",  64'(done_o), 64'd0);
        check("s5_armed", 64'(armed_o), 64'd0);
        check("s5_busy",  64'(busy_o), 64'd0);
        check("s5_left",  64'(shots_left_o), 64'd2);
        arm_i    = 1'b1;
        disarm_i = 1'b1;
        step();
        arm_i    = 1'b0;
        disarm_i = 1'b0;
        check("s5_arm_vs_disarm", 64'(armed_o), 64'd0);
        do_arm(16'd0);
        check("s5_zero_shots", 64'(shots_left_o), 64'd1);
        check("s5_zero_armed", 64'(armed_o), 64'd1);
        do_disarm();

        // Asynchronous reset in the middle of hold-off
        holdoff_i = 16'd10;
        do_arm(16'd3);
        tag_i = 64'h0000_0000_0000_00AA;
        trig_req_i = 8'h02;
        step();
        trig_req_i = 8'h00;
        check("s6_trig", 64'(trig_o), 64'd1);
        step();
        check("s6_busy_holdoff",  64'(busy_o), 64'd1);
        check("s6_armed_holdoff", 64'(armed_o), 64'd0);
        #2;
        sys_rst_i = 1'b1;
        #1;
        check("s6_rst_busy",  64'(busy_o), 64'd0);
        check("s6_rst_src",   64'(trig_src_o), 64'd0);
        check("s6_rst_tag",   trig_tag_o, 64'd0);
        check("s6_rst_left",  64'(shots_left_o), 64'd0);
        #3;
        sys_rst_i = 1'b0;
        step();
        holdoff_i = 16'd0;
        do_arm(16'd1);
        check("s6_rearm", 64'(armed_o), 64'd1);
        trig_req_i = 8'h02;
        step();
        trig_req_i = 8'h00;
        check("s6_post_trig", 64'(trig_o), 64'd1);
        check("s6_post_done", 64'(done_o), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
